// File: rtl/dual_edge_capture_pipe.sv
// rtl/dual_edge_capture_pipe.sv - launch/capture chain with posedge and negedge capture and a capture-mismatch monitor
module dual_edge_capture_pipe #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 1,
  parameter int INVERT = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic             a_valid,
  output logic [WIDTH-1:0] y,
  output logic             y_valid,
  output logic [CNT_W-1:0] mm_cnt,
  output logic             mm_flag
);

  logic [WIDTH-1:0] s [DEPTH];
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] g;
  logic             gv;
  logic [WIDTH-1:0] p;
  logic             vp;
  logic [WIDTH-1:0] n;
  logic             vn;
  logic             mismatch;

  function automatic logic [WIDTH-1:0] f(input logic [WIDTH-1:0] x);
    return (INVERT != 0) ? ~x : x;
  endfunction

  // Launch stage plus the rest of the chain; the optional inversion sits right after S0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        s[i] <= '0;
      end
      v <= '0;
    end else if (en) begin
      s[0] <= a;
      v[0] <= a_valid;
      for (int i = 1; i < DEPTH; i++) begin
        s[i] <= (i == 1) ? f(s[0]) : s[i-1];
        v[i] <= v[i-1];
      end
    end
  end

  generate
    if (DEPTH > 1) begin : g_tap_chain
      assign g = s[DEPTH-1];
    end else begin : g_tap_launch
      assign g = f(s[0]);
    end
  endgenerate

  assign gv = v[DEPTH-1];

  // Full-cycle path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p  <= '0;
      vp <= 1'b0;
    end else if (en) begin
      p  <= g;
      vp <= gv;
    end
  end

  // Half-cycle path: g only moves at posedge, so this tracks g even while stalled.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      n  <= '0;
      vn <= 1'b0;
    end else begin
      n  <= g;
      vn <= gv;
    end
  end

  assign mismatch = vn && (n != g);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_cnt  <= '0;
      mm_flag <= 1'b0;
    end else if (mismatch) begin
      mm_flag <= 1'b1;
      if (mm_cnt != {CNT_W{1'b1}}) begin
        mm_cnt <= mm_cnt + CNT_W'(1);
      end
    end
  end

  assign y       = mode ? n : p;
  assign y_valid = mode ? vn : vp;

endmodule

// File: tb/tb_dual_edge_capture_pipe.sv
// tb/tb_dual_edge_capture_pipe.sv - randomized bench for dual_edge_capture_pipe against a launch-history model
module tb_dual_edge_capture_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a = 8'h00;

  logic [7:0] y1, y3, ys;
  logic       yv1, yv3, yvs;
  logic [7:0] mc1, mc3;
  logic [1:0] mcs;
  logic       mf1, mf3, mfs;

  int vecs = 0;
  int errs = 0;

  // Model: every word accepted at an enabled posedge since reset, in order.
  logic [8:0] hist[$];
  int cnt = 0;
  int n_cnt = -100;

  always #5 clk = ~clk;

  dual_edge_capture_pipe #(.WIDTH(8), .DEPTH(1), .INVERT(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .a_valid(a_valid),
    .y(y1), .y_valid(yv1), .mm_cnt(mc1), .mm_flag(mf1));

  dual_edge_capture_pipe #(.WIDTH(8), .DEPTH(3), .INVERT(0), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .a_valid(a_valid),
    .y(y3), .y_valid(yv3), .mm_cnt(mc3), .mm_flag(mf3));

  dual_edge_capture_pipe #(.WIDTH(8), .DEPTH(1), .INVERT(1), .CNT_W(2)) us (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .a_valid(a_valid),
    .y(ys), .y_valid(yvs), .mm_cnt(mcs), .mm_flag(mfs));

  // The word visible at the chain output after k enabled edges is the one launched DEPTH edges earlier.
  function automatic logic [8:0] g_of(int k, int depth, bit inv);
    logic [8:0] e;
    if (k < depth || (k - depth) >= hist.size()) return 9'h000;
    e = hist[k - depth];
    return {e[8], inv ? ~e[7:0] : e[7:0]};
  endfunction

  function automatic logic [8:0] exp_out(int depth, bit inv, bit m);
    return m ? g_of(n_cnt, depth, inv) : g_of(cnt - 1, depth, inv);
  endfunction

  task automatic pos();
    @(posedge clk);
    if (!rst && en) begin
      hist.push_back({a_valid, a});
      cnt++;
    end
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
    if (!rst) n_cnt = cnt;
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    hist.delete();
    cnt = 0;
    n_cnt = -100;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode = 1'b0; en = 1'b1; a = 8'hA5; a_valid = 1'b1;
    pos(); neg(); pos();
    vecs++;
    if (yv1 !== 1'b1 || y1 !== 8'h5A) begin
      errs++; $display("FAIL reset_preload y=%h v=%b want 5a/1", y1, yv1);
    end
    #1 rst = 1'b1;
    hist.delete(); cnt = 0; n_cnt = -100;
    #1;
    vecs++;
    if (y1 !== 8'h00 || yv1 !== 1'b0 || mc1 !== 8'd0 || mf1 !== 1'b0) begin
      errs++; $display("FAIL reset_async_m0 y=%h v=%b cnt=%0d flag=%b want 0", y1, yv1, mc1, mf1);
    end
    mode = 1'b1;
    #1;
    vecs++;
    if (y1 !== 8'h00 || yv1 !== 1'b0 || y3 !== 8'h00 || yv3 !== 1'b0 || mc3 !== 8'd0) begin
      errs++; $display("FAIL reset_async_m1 y1=%h v1=%b y3=%h v3=%b cnt3=%0d want 0", y1, yv1, y3, yv3, mc3);
    end
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_latency_d1();
    apply_reset();
    mode = 1'b0; en = 1'b1; a = 8'h3C; a_valid = 1'b1;
    pos();
    a_valid = 1'b0; a = 8'($urandom);
    for (int m = 0; m < 2; m++) begin
      mode = m[0]; #1; vecs++;
      if (yv1 !== 1'b0) begin errs++; $display("FAIL lat1_early mode=%0d v=%b want 0", m, yv1); end
    end
    neg();
    mode = 1'b1; #1; vecs++;
    if (yv1 !== 1'b1 || y1 !== 8'hC3) begin
      errs++; $display("FAIL lat1_neg y=%h v=%b want c3/1", y1, yv1);
    end
    mode = 1'b0; #1; vecs++;
    if (yv1 !== 1'b0) begin errs++; $display("FAIL lat1_pos_early v=%b want 0", yv1); end
    pos();
    for (int m = 0; m < 2; m++) begin
      mode = m[0]; #1; vecs++;
      if (yv1 !== 1'b1 || y1 !== 8'hC3) begin
        errs++; $display("FAIL lat1_pos mode=%0d y=%h v=%b want c3/1", m, y1, yv1);
      end
    end
    neg();
  endtask

  task automatic test_latency_d3();
    logic [8:0] e;
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = (k < 3) ? 8'(k + 1) : 8'($urandom);
      a_valid = (k < 3);
      pos();
      mode = 1'b0; #1; vecs++;
      e = (k >= 3 && k <= 5) ? {1'b1, 8'(k - 2)} : 9'h000;
      if (yv3 !== e[8] || (e[8] && y3 !== e[7:0])) begin
        errs++; $display("FAIL lat3_pos k=%0d y=%h v=%b want %h/%b", k, y3, yv3, e[7:0], e[8]);
      end
      neg();
      mode = 1'b1; #1; vecs++;
      e = (k >= 2 && k <= 4) ? {1'b1, 8'(k - 1)} : 9'h000;
      if (yv3 !== e[8] || (e[8] && y3 !== e[7:0])) begin
        errs++; $display("FAIL lat3_neg k=%0d y=%h v=%b want %h/%b", k, y3, yv3, e[7:0], e[8]);
      end
    end
  endtask

  task automatic test_stall();
    logic [8:0] e;
    for (int c = 0; c < 14; c++) begin
      en = !(c >= 4 && c < 8);
      a = 8'($urandom);
      a_valid = 1'b1;
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) pos(); else neg();
        for (int m = 0; m < 2; m++) begin
          mode = m[0]; #1;
          e = exp_out(1, 1'b1, mode); vecs++;
          if (yv1 !== e[8] || (e[8] && y1 !== e[7:0])) begin
            errs++; $display("FAIL stall_u1 c=%0d ph=%0d mode=%0d y=%h v=%b want %h/%b", c, ph, m, y1, yv1, e[7:0], e[8]);
          end
          e = exp_out(3, 1'b0, mode); vecs++;
          if (yv3 !== e[8] || (e[8] && y3 !== e[7:0])) begin
            errs++; $display("FAIL stall_u3 c=%0d ph=%0d mode=%0d y=%h v=%b want %h/%b", c, ph, m, y3, yv3, e[7:0], e[8]);
          end
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_mode_toggle();
    logic [8:0] e;
    en = 1'b1;
    for (int c = 0; c < 16; c++) begin
      a = 8'($urandom);
      a_valid = ($urandom_range(0, 3) != 0);
      mode = c[0];
      pos();
      mode = ~mode; #1;
      e = exp_out(3, 1'b0, mode); vecs++;
      if (yv3 !== e[8] || (e[8] && y3 !== e[7:0])) begin
        errs++; $display("FAIL toggle_u3 c=%0d mode=%b y=%h v=%b want %h/%b", c, mode, y3, yv3, e[7:0], e[8]);
      end
      neg();
      mode = ~mode; #1;
      e = exp_out(1, 1'b1, mode); vecs++;
      if (yv1 !== e[8] || (e[8] && y1 !== e[7:0])) begin
        errs++; $display("FAIL toggle_u1 c=%0d mode=%b y=%h v=%b want %h/%b", c, mode, y1, yv1, e[7:0], e[8]);
      end
      vecs++;
      if (mc1 !== 8'd0 || mc3 !== 8'd0) begin
        errs++; $display("FAIL toggle_mm c=%0d cnt1=%0d cnt3=%0d want 0", c, mc1, mc3);
      end
    end
  endtask

  task automatic test_random();
    logic [8:0] e;
    for (int c = 0; c < 300; c++) begin
      en = ($urandom_range(0, 3) != 0);
      a = 8'($urandom);
      a_valid = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) begin
        apply_reset();
      end
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 0) pos(); else neg();
        mode = 1'($urandom); #1;
        e = exp_out(1, 1'b1, mode); vecs++;
        if (yv1 !== e[8] || (e[8] && y1 !== e[7:0])) begin
          errs++; $display("FAIL rand_u1 c=%0d ph=%0d mode=%b y=%h v=%b want %h/%b", c, ph, mode, y1, yv1, e[7:0], e[8]);
        end
        e = exp_out(3, 1'b0, mode); vecs++;
        if (yv3 !== e[8] || (e[8] && y3 !== e[7:0])) begin
          errs++; $display("FAIL rand_u3 c=%0d ph=%0d mode=%b y=%h v=%b want %h/%b", c, ph, mode, y3, yv3, e[7:0], e[8]);
        end
      end
      vecs++;
      if (mc1 !== 8'd0 || mc3 !== 8'd0 || mcs !== 2'd0 || mf1 || mf3 || mfs) begin
        errs++; $display("FAIL rand_mm c=%0d cnt=%0d/%0d/%0d flag=%b%b%b want 0", c, mc1, mc3, mcs, mf1, mf3, mfs);
      end
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    en = 1'b1; a = 8'h55; a_valid = 1'b1; mode = 1'b1;
    pos(); neg();
    force us.n = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      pos();
      vecs++;
      if (mcs !== 2'((i > 3) ? 3 : i) || mfs !== 1'b1) begin
        errs++; $display("FAIL sat_count edge=%0d cnt=%0d flag=%b want %0d/1", i, mcs, mfs, (i > 3) ? 3 : i);
      end
      neg();
    end
    release us.n;
    for (int i = 0; i < 3; i++) begin
      pos(); neg();
    end
    vecs++;
    if (mcs !== 2'd3 || mfs !== 1'b1 || mc1 !== 8'd0 || mf1 !== 1'b0) begin
      errs++; $display("FAIL sat_hold cnt=%0d flag=%b u1cnt=%0d u1flag=%b want 3/1/0/0", mcs, mfs, mc1, mf1);
    end
    apply_reset();
    #1; vecs++;
    if (mcs !== 2'd0 || mfs !== 1'b0) begin
      errs++; $display("FAIL sat_clear cnt=%0d flag=%b want 0/0", mcs, mfs);
    end
  endtask

  initial begin
    #1;
    vecs++;
    if (yv1 !== 1'b0 || y1 !== 8'h00 || yv3 !== 1'b0 || mc1 !== 8'd0 || mf1 !== 1'b0) begin
      errs++; $display("FAIL power_on_reset y=%h v=%b v3=%b cnt=%0d flag=%b want 0", y1, yv1, yv3, mc1, mf1);
    end
    apply_reset();
    test_reset();
    test_latency_d1();
    test_latency_d3();
    test_stall();
    test_mode_toggle();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
